// File: rtl/cfg_sequencer.sv
// cfg_sequencer: assembles a PE-array config vector from a word stream,
// then strobes ld_reg, holds rd_reg for run_len cycles and pulses done.
module cfg_sequencer #(
  parameter int NUM_PEs_PER_ROW = 4,
  parameter int NUM_ROWS        = 4,
  parameter int WORD_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  input  logic [WORD_WIDTH-1:0]   cfg_data,
  output logic                    cfg_ready,
  input  logic [15:0]             run_len,
  input  logic                    abort,
  output logic                    ld_reg,
  output logic                    rd_reg,
  output logic [NUM_PEs_PER_ROW*NUM_ROWS-1:0] clk_en_o,
  output logic [NUM_PEs_PER_ROW*NUM_ROWS-1:0] adder_en_o,
  output logic [NUM_PEs_PER_ROW*NUM_ROWS-1:0] visible_o,
  output logic                    rst_acc_o,
  output logic [2*NUM_ROWS-1:0]   task_ctrl_o,
  output logic                    busy,
  output logic                    done
);

  localparam int P         = NUM_PEs_PER_ROW * NUM_ROWS;
  localparam int CFG_W     = 3 * P + 1 + 2 * NUM_ROWS;
  localparam int NUM_WORDS = (CFG_W + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMMIT,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [CW-1:0]    word_cnt;
  logic [15:0]      run_cnt;
  logic [CFG_W-1:0] shadow;
  logic [CFG_W-1:0] shadow_d;
  logic             accept;
  logic             last_word;
  logic             ld_d;
  logic             rd_d;
  logic             done_d;

  // Handshake: only IDLE/LOAD take words, and never while aborting or in reset.
  always_comb begin
    cfg_ready = 1'b0;
    if (!rst && !abort && (state == IDLE || state == LOAD))
      cfg_ready = 1'b1;
  end

  assign accept    = cfg_valid && cfg_ready;
  assign last_word = (word_cnt == CW'(NUM_WORDS - 1));

  // Merge the incoming word into its slot; bits past CFG_W fall away.
  always_comb begin
    shadow_d = shadow;
    for (int b = 0; b < CFG_W; b++) begin
      if (b / WORD_WIDTH == int'(word_cnt))
        shadow_d[b] = cfg_data[b % WORD_WIDTH];
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_d = state;
    ld_d    = 1'b0;
    rd_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept)
          state_d = last_word ? COMMIT : LOAD;
      end
      LOAD: begin
        if (abort)
          state_d = IDLE;
        else if (accept && last_word)
          state_d = COMMIT;
      end
      COMMIT: begin
        ld_d    = 1'b1;
        state_d = (run_cnt != 16'd0) ? RUN : DONE;
      end
      RUN: begin
        rd_d = 1'b1;
        if (abort)
          state_d = IDLE;
        else if (run_cnt == 16'd1)
          state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, slot counter, run counter and shadow register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_cnt <= '0;
      run_cnt  <= '0;
      shadow   <= '0;
    end else begin
      state <= state_d;
      if (accept)
        shadow <= shadow_d;
      if (state == LOAD && abort)
        word_cnt <= '0;
      else if (accept)
        word_cnt <= last_word ? '0 : word_cnt + CW'(1);
      if (accept && last_word)
        run_cnt <= run_len;
      else if (state == RUN)
        run_cnt <= abort ? 16'd0 : run_cnt - 16'd1;
    end
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    ld_reg      = ld_d && !rst;
    rd_reg      = rd_d && !rst;
    done        = done_d && !rst;
    busy        = (state != IDLE) && !rst;
    clk_en_o    = rst ? '0 : shadow[P-1:0];
    adder_en_o  = rst ? '0 : shadow[2*P-1:P];
    visible_o   = rst ? '0 : shadow[3*P-1:2*P];
    rst_acc_o   = rst ? 1'b0 : shadow[3*P];
    task_ctrl_o = rst ? '0 : shadow[3*P+2*NUM_ROWS:3*P+1];
  end

endmodule

// File: tb/tb_cfg_sequencer.sv
// tb_cfg_sequencer: directed plus randomized loads of cfg_sequencer,
// checked against a word-slot model and event-cycle bookkeeping.
module tb_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [15:0] cfg_data;
  logic        cfg_ready;
  logic [15:0] run_len;
  logic        abort;
  logic        ld_reg;
  logic        rd_reg;
  logic [15:0] clk_en_o;
  logic [15:0] adder_en_o;
  logic [15:0] visible_o;
  logic        rst_acc_o;
  logic [7:0]  task_ctrl_o;
  logic        busy;
  logic        done;

  cfg_sequencer dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .run_len(run_len), .abort(abort),
    .ld_reg(ld_reg), .rd_reg(rd_reg),
    .clk_en_o(clk_en_o), .adder_en_o(adder_en_o), .visible_o(visible_o),
    .rst_acc_o(rst_acc_o), .task_ctrl_o(task_ctrl_o),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ld_cnt = 0, rd_cnt = 0, rd_runs = 0, done_cnt = 0, ovl = 0;
  int ld_cyc = 0, rd_first = 0, rd_last = 0, done_cyc = 0;
  logic prev_rd = 1'b0;

  always @(negedge clk) begin
    if (ld_reg) begin ld_cnt <= ld_cnt + 1; ld_cyc <= cyc; end
    if (rd_reg) begin rd_cnt <= rd_cnt + 1; rd_last <= cyc; end
    if (rd_reg && !prev_rd) begin rd_runs <= rd_runs + 1; rd_first <= cyc; end
    if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (ld_reg && rd_reg) ovl <= ovl + 1;
    prev_rd <= rd_reg;
  end

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: four word slots plus the slot the next accepted word lands in.
  logic [15:0] mw [4];
  int mslot = 0;

  function automatic logic [63:0] exp_vec();
    logic [63:0] v = 64'd0;
    for (int k = 0; k < 4; k++) v = v | (64'(mw[k]) << (16 * k));
    return v & ((64'd1 << 57) - 64'd1);
  endfunction

  task automatic chk_fields(input string tag);
    logic [63:0] v = exp_vec();
    chk({tag, ".clk_en"}, 64'(clk_en_o), 64'(v[15:0]));
    chk({tag, ".adder_en"}, 64'(adder_en_o), 64'(v[31:16]));
    chk({tag, ".visible"}, 64'(visible_o), 64'(v[47:32]));
    chk({tag, ".rst_acc"}, 64'(rst_acc_o), 64'(v[48]));
    chk({tag, ".task_ctrl"}, 64'(task_ctrl_o), 64'(v[56:49]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, output int n);
    cfg_valid = 1'b1;
    cfg_data  = d;
    @(negedge clk);
    n = cyc;
    chk("ready", 64'(cfg_ready), 64'd1);
    tick();
    cfg_valid = 1'b0;
    mw[mslot] = d;
    mslot = (mslot + 1) % 4;
  endtask

  // After the last word (cycle n): watch ld/rd/done timing, with optional
  // noise on cfg_valid and an abort pulse during COMMIT.
  task automatic complete(input string tag, input int n, input int rl,
                          input bit noise, input bit ab_commit);
    int l0 = ld_cnt, r0 = rd_cnt, ru0 = rd_runs, d0 = done_cnt;
    run_len = 16'($urandom);
    if (ab_commit) abort = 1'b1;
    for (int i = 0; i < rl + 8 && done_cnt == d0; i++) begin
      if (noise) begin
        cfg_valid = 1'($urandom);
        cfg_data  = 16'($urandom);
      end
      tick();
      abort = 1'b0;
    end
    cfg_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".ld_n"}, 64'(ld_cnt - l0), 64'd1);
    chk({tag, ".ld_cyc"}, 64'(ld_cyc), 64'(n + 1));
    chk({tag, ".rd_n"}, 64'(rd_cnt - r0), 64'(rl));
    if (rl > 0) begin
      chk({tag, ".rd_runs"}, 64'(rd_runs - ru0), 64'd1);
      chk({tag, ".rd_first"}, 64'(rd_first), 64'(n + 2));
      chk({tag, ".rd_last"}, 64'(rd_last), 64'(n + 1 + rl));
    end
    chk({tag, ".done_n"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, ".done_cyc"}, 64'(done_cyc), 64'(n + 2 + rl));
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".ovl"}, 64'(ovl), 64'd0);
    chk_fields(tag);
    tick();
  endtask

  task automatic load(input string tag, input logic [15:0] w0, w1, w2, w3,
                      input int rl, input int gap, input bit noise, input bit abc);
    int n;
    run_len = 16'($urandom);
    send(w0, n);
    send(w1, n);
    repeat (gap) tick();
    send(w2, n);
    run_len = 16'(rl);
    send(w3, n);
    complete(tag, n, rl, noise, abc);
  endtask

  initial begin
    int n, l0, r0, d0, t0;
    for (int k = 0; k < 4; k++) mw[k] = 16'd0;
    rst = 1'b1; abort = 1'b0; cfg_valid = 1'b1; cfg_data = 16'hFFFF;
    run_len = 16'd0;
    @(negedge clk);
    chk("rst.ready", 64'(cfg_ready), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.strobes", 64'({ld_reg, rd_reg, done}), 64'd0);
    tick(); tick();
    chk_fields("rst");
    rst = 1'b0; cfg_valid = 1'b0;
    tick();

    load("basic", 16'hAAAA, 16'h5555, 16'h0F0F, 16'h0123, 3, 0, 0, 0);
    chk("basic.clk_en_k", 64'(clk_en_o), 64'hAAAA);
    chk("basic.adder_en_k", 64'(adder_en_o), 64'h5555);
    chk("basic.visible_k", 64'(visible_o), 64'h0F0F);
    chk("basic.rst_acc_k", 64'(rst_acc_o), 64'd1);
    chk("basic.task_k", 64'(task_ctrl_o), 64'h91);

    load("rl0", 16'hAAAA, 16'h5555, 16'h0F0F, 16'h0123, 0, 0, 0, 0);
    load("gap", 16'hAAAA, 16'h5555, 16'h0F0F, 16'h0123, 3, 2, 0, 0);
    load("ab_commit", 16'h1357, 16'h2468, 16'h9ABC, 16'hFFFF, 2, 0, 1, 1);

    // Abort in the second RUN cycle.
    send(16'h1111, n); send(16'h2222, n); send(16'h3333, n);
    run_len = 16'd10;
    send(16'h4444, n);
    l0 = ld_cnt; r0 = rd_cnt; d0 = done_cnt;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abrun.rd", 64'(rd_reg), 64'd0);
    chk("abrun.busy", 64'(busy), 64'd0);
    repeat (14) tick();
    chk("abrun.done_n", 64'(done_cnt - d0), 64'd0);
    chk("abrun.rd_n", 64'(rd_cnt - r0), 64'd2);
    chk("abrun.ld_n", 64'(ld_cnt - l0), 64'd1);
    chk_fields("abrun");
    load("after_abrun", 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h0001, 1, 0, 0, 0);

    // Abort alongside word 2: dropped, next word restarts at slot 0.
    send(16'hA0A0, n); send(16'hA1A1, n);
    cfg_valid = 1'b1; cfg_data = 16'hA2A2; abort = 1'b1;
    @(negedge clk);
    chk("abw.ready", 64'(cfg_ready), 64'd0);
    tick();
    abort = 1'b0; cfg_valid = 1'b0; mslot = 0;
    @(negedge clk);
    chk("abw.busy", 64'(busy), 64'd0);
    chk_fields("abw.kept");
    tick();
    send(16'hB0B0, n);
    chk_fields("abw.slot0");
    send(16'hB1B1, n); send(16'hB2B2, n);
    run_len = 16'd2;
    send(16'hB3B3, n);
    complete("abw.done", n, 2, 0, 0);

    // Reset after three of four words.
    send(16'h7777, n); send(16'h8888, n); send(16'h9999, n);
    l0 = ld_cnt;
    rst = 1'b1; cfg_valid = 1'b1; cfg_data = 16'h5A5A;
    @(negedge clk);
    chk("rstld.ready", 64'(cfg_ready), 64'd0);
    chk("rstld.busy", 64'(busy), 64'd0);
    tick();
    for (int k = 0; k < 4; k++) mw[k] = 16'd0;
    mslot = 0;
    chk_fields("rstld");
    rst = 1'b0; cfg_valid = 1'b0;
    repeat (6) tick();
    chk("rstld.ld_n", 64'(ld_cnt - l0), 64'd0);
    load("after_rst", 16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00, 2, 1, 0, 0);

    // Reset in the middle of RUN.
    send(16'h1234, n); send(16'h5678, n); send(16'h9ABC, n);
    run_len = 16'd8;
    send(16'hDEF0, n);
    d0 = done_cnt;
    repeat (4) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstrun.rd", 64'(rd_reg), 64'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) mw[k] = 16'd0;
    mslot = 0;
    r0 = rd_cnt;
    repeat (12) tick();
    chk("rstrun.done_n", 64'(done_cnt - d0), 64'd0);
    chk("rstrun.rd_n", 64'(rd_cnt - r0), 64'd0);

    for (int it = 0; it < 10; it++) begin
      t0 = it;
      load($sformatf("rand%0d", t0), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), int'($urandom_range(0, 6)),
           int'($urandom_range(0, 2)), 1'b1, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cfg_sequencer.md
CFG_SEQUENCER -- requirements
Module: cfg_sequencer

Interface
- REQ-001: Parameter NUM_PEs_PER_ROW, default 4, PEs per row.
- REQ-002: Parameter NUM_ROWS, default 4, PE rows.
- REQ-003: Parameter WORD_WIDTH, default 16, config stream word width.
- REQ-004: Derived: P = NUM_PEs_PER_ROW*NUM_ROWS; CFG_W = 3*P + 1 + 2*NUM_ROWS; NUM_WORDS = ceil(CFG_W/WORD_WIDTH) (defaults: P=16, CFG_W=57, NUM_WORDS=4).
- REQ-005: The block uses one clock and a synchronous, active-high reset: clk input 1 (sole clock, all logic on posedge), then rst input 1 (synchronous, active-high).
- REQ-006: cfg_valid  input  1  config word present.
- REQ-007: cfg_data  input  WORD_WIDTH  config word, LSB-first packing.
- REQ-008: cfg_ready  output  1  word accepted when cfg_valid&&cfg_ready.
- REQ-009: run_len  input  16  rd_reg hold length, sampled with the last word.
- REQ-010: abort  input  1  cancel load or run.
- REQ-011: ld_reg  output  1  one-cycle load strobe to the config register bank.
- REQ-012: rd_reg  output  1  read-enable to the config register bank.
- REQ-013: clk_en_o, adder_en_o, visible_o  output  P each  assembled fields.
- REQ-014: rst_acc_o  output  1; task_ctrl_o  output  2*NUM_ROWS  assembled fields.
- REQ-015: busy  output  1  high in any state except IDLE; done  output  1  one-cycle completion pulse.

Function
- REQ-016: The shadow vector SHALL be packed as bits [P-1:0] clk_en, [2P-1:P] adder_en, [3P-1:2P] visible, [3P] rst_acc, [3P+2R:3P+1] task_ctrl; word k SHALL fill bits [k*WORD_WIDTH +: WORD_WIDTH]; bits at or above CFG_W SHALL be discarded.
- REQ-017: The field outputs SHALL be driven continuously from the shadow register and SHALL change only on word acceptance or reset.
- REQ-018: The FSM SHALL have the states IDLE, LOAD, COMMIT, RUN and DONE.
- REQ-019: cfg_ready SHALL equal (state==IDLE || state==LOAD) && !abort.
- REQ-020: IDLE: accepting a word SHALL store word 0, set word_cnt=1 and go to LOAD (NUM_WORDS==1 goes directly to COMMIT).
- REQ-021: LOAD: each accepted word SHALL store into slot word_cnt and increment word_cnt; when word NUM_WORDS-1 is accepted, the block SHALL latch run_len and go to COMMIT.
- REQ-022: COMMIT: ld_reg SHALL be high for exactly this one cycle; the next state SHALL be RUN if the latched run_len is nonzero, else DONE.
- REQ-023: RUN: rd_reg SHALL be high for exactly run_len consecutive cycles via a down-counter, then the block SHALL go to DONE.
- REQ-024: DONE: done SHALL be high for one cycle, then the block SHALL go to IDLE.
- REQ-025: Latency: last word accepted in cycle N -> ld_reg in N+1 -> rd_reg in N+2..N+1+run_len -> done in N+2+run_len (N+2 when run_len=0).
- REQ-026: ld_reg and rd_reg SHALL never be high in the same cycle.
- REQ-027: abort in LOAD or RUN SHALL go to IDLE on the next edge, clear word_cnt and the run counter, drop rd_reg that edge and suppress done; the shadow contents SHALL be retained.
- REQ-028: abort in COMMIT or DONE SHALL be ignored.
- REQ-029: abort together with cfg_valid SHALL mean the word is not accepted.
- REQ-030: Gaps in cfg_valid during LOAD SHALL stall the load with no timeout.
- REQ-031: cfg_valid during COMMIT, RUN or DONE SHALL be ignored (cfg_ready low).

Reset
- REQ-032: While rst is high, the block SHALL go to IDLE and clear word_cnt, the run counter and the shadow vector.
- REQ-033: While rst is high, ld_reg, rd_reg, done and busy SHALL be 0, all field outputs 0 and cfg_ready 0.
- REQ-034: Reset asserted mid-LOAD or mid-RUN SHALL take effect on that edge, with no ld_reg or done afterwards.

Verification (defaults)
- REQ-035: Words 0xAAAA, 0x5555, 0x0F0F, 0x0123 back-to-back with run_len=3 -> clk_en_o=0xAAAA, adder_en_o=0x5555, visible_o=0x0F0F, rst_acc_o=1, task_ctrl_o=0x91; ld_reg 1 cycle; rd_reg 3 cycles; then done.
- REQ-036: Same load with run_len=0 -> ld_reg one cycle, done the next cycle, rd_reg never high.
- REQ-037: Two idle cycles inserted between words 1 and 2 -> identical fields; ld_reg delayed by 2 cycles.
- REQ-038: abort in cycle 2 of RUN (run_len=10) -> rd_reg low next cycle, no done, busy=0; a new 4-word load then completes normally.
- REQ-039: abort with cfg_valid on word 2 -> word not accepted, word_cnt=0; the next accepted word goes to slot 0.
- REQ-040: rst after 3 of 4 words -> all outputs 0, no ld_reg; a fresh 4-word load succeeds.
